// File: rtl/mem_stage_mq.sv
// mem_stage_mq: in-order multi-slot MEM stage between EX and WB.
// Optional MS_DATA_BYPASS_EN: forward data_ok rdata straight to WB.
module mem_stage_mq #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es2ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic        es_mem_req,
  input  logic        es_res_from_mem,
  input  logic [4:0]  es_ld_op,
  input  logic        es_rf_we,
  input  logic [4:0]  es_rf_waddr,
  input  logic [31:0] es_result,
  input  logic        es_ex,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms2ws_valid,
  output logic [31:0] ms_pc,
  output logic        ms_rf_we,
  output logic [4:0]  ms_rf_waddr,
  output logic [31:0] ms_rf_wdata,
  output logic        ms_ex,
  output logic        ms_ld_blk,
  input  logic        wb_ex
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        mem_req;
    logic        res_mem;
    logic [4:0]  ld_op;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] result;
    logic        ex;
  } slot_t;

  slot_t            slot [DEPTH];
  logic [31:0]      dbuf [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] dvld;
  logic [PW-1:0]    hd;
  logic [PW-1:0]    tl;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] discard;

  logic [PW-1:0]    idx;
  logic [PW-1:0]    pidx;
  logic             pfound;
  logic [CNT_W-1:0] pcnt;
  logic             blk;

  // Walk slots oldest-first to find the request data_ok belongs to.
  always_comb begin
    pfound = 1'b0;
    pidx   = hd;
    pcnt   = '0;
    blk    = 1'b0;
    idx    = hd;
    for (int i = 0; i < DEPTH; i++) begin
      idx = hd + PW'(i);
      if (vld[idx] && slot[idx].mem_req && !dvld[idx]) begin
        pcnt = pcnt + CNT_W'(1);
        if (!pfound) begin
          pfound = 1'b1;
          pidx   = idx;
        end
      end
      if (vld[idx] && slot[idx].res_mem && !dvld[idx])
        blk = 1'b1;
    end
  end

  slot_t       head;
  logic        dok_disc;
  logic        fill;
  logic        head_match;
  logic        head_rdy;
  logic [31:0] word;
  logic [31:0] sh;
  logic [31:0] ext;
  logic        deq;
  logic        enq;

  assign head       = slot[hd];
  assign dok_disc   = data_sram_data_ok & (discard != '0);
  assign fill       = data_sram_data_ok & (discard == '0) & pfound;
  assign head_match = fill & (pidx == hd);

`ifdef MS_DATA_BYPASS_EN
  assign head_rdy = ~head.mem_req | dvld[hd] | head_match;
  assign word     = dvld[hd] ? dbuf[hd] : data_sram_rdata;
`else
  assign head_rdy = ~head.mem_req | dvld[hd];
  assign word     = dbuf[hd];
  logic unused_match;
  assign unused_match = head_match;
`endif

  assign sh = word >> {head.result[1:0], 3'b000};

  always_comb begin
    ext = sh;
    unique case (1'b1)
      head.ld_op[4]: ext = {{24{sh[7]}}, sh[7:0]};
      head.ld_op[3]: ext = {24'b0, sh[7:0]};
      head.ld_op[2]: ext = {{16{sh[15]}}, sh[15:0]};
      head.ld_op[1]: ext = {16'b0, sh[15:0]};
      head.ld_op[0]: ext = sh;
      default:       ext = sh;
    endcase
  end

  assign ms2ws_valid = vld[hd] & head_rdy & ~wb_ex;
  assign deq         = ms2ws_valid & ws_allowin;
  assign ms_allowin  = (cnt < CNT_W'(DEPTH)) | deq;
  assign enq         = es2ms_valid & ms_allowin & ~wb_ex;

  assign ms_pc       = vld[hd] ? head.pc : 32'b0;
  assign ms_rf_waddr = vld[hd] ? head.waddr : 5'b0;
  assign ms_rf_wdata = !vld[hd]    ? 32'b0 :
                       head.res_mem ? ext : head.result;
  assign ms_rf_we    = head.rf_we & ms2ws_valid;
  assign ms_ex       = vld[hd] & head.ex;
  assign ms_ld_blk   = blk & ~wb_ex;

  // On flush, every still-pending request (minus one filled now)
  // plus the one EX issues this cycle must have its data dropped.
  logic [CNT_W-1:0] flush_add;
  logic [CNT_W-1:0] disc_nxt;

  assign flush_add = (pcnt - CNT_W'(fill))
                   + CNT_W'(es2ms_valid & es_mem_req);
  assign disc_nxt  = discard - CNT_W'(dok_disc)
                   + (wb_ex ? flush_add : '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld     <= '0;
      hd      <= '0;
      tl      <= '0;
      cnt     <= '0;
      discard <= '0;
    end else begin
      discard <= disc_nxt;
      if (wb_ex) begin
        vld <= '0;
        hd  <= '0;
        tl  <= '0;
        cnt <= '0;
      end else begin
        if (fill) begin
          dbuf[pidx] <= data_sram_rdata;
          dvld[pidx] <= 1'b1;
        end
        if (deq) begin
          vld[hd] <= 1'b0;
          hd      <= hd + PW'(1);
        end
        if (enq) begin
          slot[tl] <= '{pc: es_pc, mem_req: es_mem_req,
                        res_mem: es_res_from_mem,
                        ld_op: es_ld_op, rf_we: es_rf_we,
                        waddr: es_rf_waddr,
                        result: es_result, ex: es_ex};
          vld[tl]  <= 1'b1;
          dvld[tl] <= 1'b0;
          tl       <= tl + PW'(1);
        end
        cnt <= cnt + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_mq.sv
// tb_mem_stage_mq: queue-model checker plus directed scenarios
// for the multi-slot MEM stage.
module tb_mem_stage_mq;

  localparam int DEPTH = 2;
`ifdef MS_DATA_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        es2ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic        es_mem_req;
  logic        es_res_from_mem;
  logic [4:0]  es_ld_op;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_result;
  logic        es_ex;
  logic        data_ok;
  logic [31:0] rdata;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [31:0] ms_pc;
  logic        ms_rf_we;
  logic [4:0]  ms_rf_waddr;
  logic [31:0] ms_rf_wdata;
  logic        ms_ex;
  logic        ms_ld_blk;
  logic        wb_ex;

  mem_stage_mq #(.DEPTH(DEPTH), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .es2ms_valid(es2ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_mem_req(es_mem_req),
    .es_res_from_mem(es_res_from_mem), .es_ld_op(es_ld_op),
    .es_rf_we(es_rf_we), .es_rf_waddr(es_rf_waddr),
    .es_result(es_result), .es_ex(es_ex),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
    .ws_allowin(ws_allowin), .ms2ws_valid(ms2ws_valid),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we),
    .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
    .ms_ex(ms_ex), .ms_ld_blk(ms_ld_blk), .wb_ex(wb_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          mem_req;
    bit          res_mem;
    logic [4:0]  ld_op;
    bit          rf_we;
    logic [4:0]  waddr;
    logic [31:0] result;
    bit          ex;
    bit          have;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          disc;
  int          checks;
  int          failures;
  bit          chk_en;
  logic [31:0] wb_log[$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [4:0] op,
      input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (int'(lo) * 8);
    if (op[4]) return {{24{s[7]}}, s[7:0]};
    if (op[3]) return {24'b0, s[7:0]};
    if (op[2]) return {{16{s[15]}}, s[15:0]};
    if (op[1]) return {16'b0, s[15:0]};
    return s;
  endfunction

  always @(negedge clk) begin
    int          p;
    int          pend;
    bit          fill;
    bit          ev;
    bit          ea;
    bit          eb;
    logic [31:0] w;
    logic [31:0] ed;
    p = -1;
    pend = 0;
    eb = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].mem_req && !mq[i].have) begin
        pend++;
        if (p < 0) p = i;
      end
      if (mq[i].res_mem && !mq[i].have) eb = 1'b1;
    end
    eb = eb && !wb_ex;
    fill = data_ok && disc == 0 && p >= 0;
    ev = 1'b0;
    ed = 32'b0;
    if (mq.size() > 0) begin
      ev = (!mq[0].mem_req || mq[0].have || (BYP && fill && p == 0))
           && !wb_ex;
      w = mq[0].have ? mq[0].data : rdata;
      ed = mq[0].res_mem ? load_val(mq[0].ld_op, mq[0].result[1:0], w)
                         : mq[0].result;
    end
    ea = mq.size() < DEPTH || (ev && ws_allowin);
    if (chk_en) begin
      chk("valid", ms2ws_valid, ev);
      chk("allowin", ms_allowin, ea);
      chk("ld_blk", ms_ld_blk, eb);
      chk("rf_we", ms_rf_we, ev && mq[0].rf_we);
      chk("ex", ms_ex, mq.size() > 0 && mq[0].ex);
      chk("pc", ms_pc, mq.size() > 0 ? mq[0].pc : 32'b0);
      chk("waddr", ms_rf_waddr, mq.size() > 0 ? mq[0].waddr : 5'b0);
      if (ev || mq.size() == 0) chk("wdata", ms_rf_wdata, ed);
      if (ms2ws_valid && ws_allowin) wb_log.push_back(ms_rf_wdata);
    end
    if (!resetn) begin
      mq.delete();
      disc = 0;
    end else if (wb_ex) begin
      if (data_ok) begin
        if (disc > 0) disc--;
        else if (p >= 0) pend--;
      end
      disc += pend + ((es2ms_valid && es_mem_req) ? 1 : 0);
      mq.delete();
    end else begin
      if (data_ok) begin
        if (disc > 0) disc--;
        else if (p >= 0) begin
          mq[p].have = 1'b1;
          mq[p].data = rdata;
        end
      end
      if (ev && ws_allowin) void'(mq.pop_front());
      if (es2ms_valid && ea) begin
        ent_t e;
        e.pc = es_pc;           e.mem_req = es_mem_req;
        e.res_mem = es_res_from_mem;
        e.ld_op = es_ld_op;     e.rf_we = es_rf_we;
        e.waddr = es_rf_waddr;  e.result = es_result;
        e.ex = es_ex;           e.have = 1'b0;
        e.data = 32'b0;
        mq.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    es2ms_valid = 1'b0;
    es_mem_req  = 1'b0;
    es_ex       = 1'b0;
    data_ok     = 1'b0;
    wb_ex       = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic issue(input logic [31:0] pc, input bit mreq,
      input bit rmem, input logic [4:0] op, input logic [31:0] res,
      input logic [4:0] wa, input bit ex);
    es2ms_valid     = 1'b1;
    es_pc           = pc;
    es_mem_req      = mreq;
    es_res_from_mem = rmem;
    es_ld_op        = op;
    es_rf_we        = 1'b1;
    es_rf_waddr     = wa;
    es_result       = res;
    es_ex           = ex;
  endtask

  task automatic dok(input logic [31:0] d);
    data_ok = 1'b1;
    rdata   = d;
  endtask

  function automatic logic [31:0] lg(input int i);
    return (i < wb_log.size()) ? wb_log[i] : 32'hDEADDEAD;
  endfunction

  initial begin
    checks = 0; failures = 0; chk_en = 1'b0; disc = 0;
    resetn = 1'b0; ws_allowin = 1'b1; rdata = 32'b0;
    es_pc = 0; es_res_from_mem = 0; es_ld_op = 0; es_rf_we = 0;
    es_rf_waddr = 0; es_result = 0;
    es2ms_valid = 0; es_mem_req = 0; es_ex = 0; data_ok = 0; wb_ex = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_valid", ms2ws_valid, 0);
    chk("rst_ld_blk", ms_ld_blk, 0);
    chk("rst_wdata", ms_rf_wdata, 0);

    // back-to-back loads
    step();
    issue(32'h1000, 1, 1, 5'b00001, 32'h100, 5'd1, 0); step();
    issue(32'h1004, 1, 1, 5'b00001, 32'h104, 5'd2, 0); step();
    dok(32'hAAAA0001);
    @(negedge clk);
    chk("b2b_ld_blk", ms_ld_blk, 1);
    step();
    dok(32'hBBBB0002); step();
    idle(3);
    chk("b2b_n", wb_log.size(), 2);
    chk("b2b_0", lg(0), 32'hAAAA0001);
    chk("b2b_1", lg(1), 32'hBBBB0002);
    wb_log.delete();

    // byte/half extraction
    issue(32'h2000, 1, 1, 5'b10000, 32'h203, 5'd3, 0); step();
    dok(32'h80123456); step();
    issue(32'h2004, 1, 1, 5'b00010, 32'h202, 5'd4, 0); step();
    dok(32'h80123456); step();
    issue(32'h2008, 1, 1, 5'b00100, 32'h200, 5'd5, 0); step();
    dok(32'h80123456); step();
    idle(3);
    chk("ext_n", wb_log.size(), 3);
    chk("ext_ldb", lg(0), 32'hFFFFFF80);
    chk("ext_ldhu", lg(1), 32'h00008012);
    chk("ext_ldh", lg(2), 32'h00003456);
    wb_log.delete();

    // full FIFO with WB stall
    ws_allowin = 1'b0;
    issue(32'h3000, 0, 0, 5'b0, 32'h11, 5'd6, 0); step();
    issue(32'h3004, 0, 0, 5'b0, 32'h22, 5'd7, 0); step();
    @(negedge clk);
    chk("full_allowin", ms_allowin, 0);
    chk("full_valid", ms2ws_valid, 1);
    step();
    ws_allowin = 1'b1;
    issue(32'h3008, 0, 0, 5'b0, 32'h33, 5'd8, 0);
    @(negedge clk);
    chk("full_release", ms_allowin, 1);
    step();
    idle(3);
    chk("full_n", wb_log.size(), 3);
    chk("full_2", lg(2), 32'h33);
    wb_log.delete();

    // flush with in-flight requests
    issue(32'h4000, 1, 1, 5'b00001, 32'h400, 5'd9, 0); step();
    issue(32'h4004, 1, 1, 5'b00001, 32'h404, 5'd10, 0); step();
    wb_ex = 1'b1;
    issue(32'h4008, 1, 1, 5'b00001, 32'h408, 5'd11, 0); step();
    dok(32'hDEAD0001); step();
    dok(32'hDEAD0002); step();
    dok(32'hDEAD0003); step();
    idle(1);
    chk("flush_drop_n", wb_log.size(), 0);
    issue(32'h4010, 1, 1, 5'b00001, 32'h408, 5'd12, 0); step();
    dok(32'h44440004); step();
    idle(3);
    chk("flush_n", wb_log.size(), 1);
    chk("flush_4th", lg(0), 32'h44440004);
    wb_log.delete();

    // flush coincident with data_ok
    issue(32'h5000, 1, 1, 5'b00001, 32'h500, 5'd13, 0); step();
    dok(32'h55555555);
    wb_ex = 1'b1;
    step();
    idle(1);
    issue(32'h5004, 1, 1, 5'b00001, 32'h504, 5'd14, 0); step();
    dok(32'h66666666); step();
    idle(3);
    chk("coinc_n", wb_log.size(), 1);
    chk("coinc_data", lg(0), 32'h66666666);
    wb_log.delete();

    // ALU op held behind a pending load
    issue(32'h6000, 1, 1, 5'b00001, 32'h600, 5'd15, 0); step();
    issue(32'h6004, 0, 0, 5'b0, 32'h1234, 5'd16, 0); step();
    idle(2);
    chk("order_hold", wb_log.size(), 0);
    dok(32'h77777777); step();
    idle(3);
    chk("order_n", wb_log.size(), 2);
    chk("order_0", lg(0), 32'h77777777);
    chk("order_1", lg(1), 32'h1234);
    wb_log.delete();

    // exception-tagged instruction
    issue(32'h7000, 0, 0, 5'b0, 32'h7, 5'd17, 1); step();
    @(negedge clk);
    chk("ex_head", ms_ex, 1);
    step();
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
